// File: rtl/muldiv_seq_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package muldiv_seq_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ITER_COUNT = 32;
  localparam int unsigned CNT_W      = $clog2(ITER_COUNT);

  typedef logic [XLEN-1:0] reg_t;

  typedef enum logic [1:0] {
    OP_MUL   = 2'd0,
    OP_MULHU = 2'd1,
    OP_DIVU  = 2'd2,
    OP_REMU  = 2'd3
  } muldiv_op_e;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Division ops use the restoring-divide iteration; the rest use shift-add.
  function automatic logic is_div(input muldiv_op_e op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  // MUL and DIVU return the low/quotient word; MULHU and REMU the high/remainder word.
  function automatic logic sel_low(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_seq_alu.sv
// Shared add/subtract unit: one adder, subtract via inverted operand plus carry-in.
module muldiv_seq_alu
  import muldiv_seq_pkg::*;
(
  input  alu_op_e op,
  input  reg_t    a,
  input  reg_t    b,
  output reg_t    result_c
);

  logic sub;

  // Two's-complement subtract folded into the single adder.
  always_comb begin
    sub      = (op == ALU_SUB);
    result_c = a + (b ^ {XLEN{sub}}) + XLEN'(sub);
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative 32-cycle unsigned multiplier/divider with valid/ready handshakes.
// hi/lo hold {hi,lo} for multiply and {rem,quo} for divide.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  muldiv_op_e req_op,
  input  reg_t       req_a,
  input  reg_t       req_b,
  output logic       resp_valid,
  input  logic       resp_ready,
  output reg_t       resp_result,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);

  state_e           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  muldiv_op_e       op_q, op_next;
  reg_t             b_q, b_next;
  reg_t             hi, hi_next;
  reg_t             lo, lo_next;
  reg_t             result_next;

  alu_op_e          alu_op;
  reg_t             alu_a, alu_b, alu_y;
  logic [XLEN:0]    sh;
  reg_t             sum;
  logic             carry;
  logic             take;
  reg_t             iter_hi, iter_lo;

  muldiv_seq_alu u_alu (
    .op       (alu_op),
    .a        (alu_a),
    .b        (alu_b),
    .result_c (alu_y)
  );

  // ALU operand selection by state and operation.
  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = '0;
    alu_b  = '0;
    if (state == ST_RUN) begin
      if (is_div(op_q)) begin
        alu_op = ALU_SUB;
        alu_a  = sh[XLEN-1:0];
        alu_b  = b_q;
      end else begin
        alu_op = ALU_ADD;
        alu_a  = hi;
        alu_b  = b_q;
      end
    end
  end

  // One shift-add or restoring-divide step.
  always_comb begin
    sh      = {hi, lo[XLEN-1]};
    sum     = hi;
    carry   = 1'b0;
    take    = 1'b0;
    iter_hi = hi;
    iter_lo = lo;
    if (is_div(op_q)) begin
      take    = sh[XLEN] | (sh[XLEN-1:0] >= b_q);
      iter_hi = take ? alu_y : sh[XLEN-1:0];
      iter_lo = {lo[XLEN-2:0], take};
    end else begin
      if (lo[0]) begin
        sum   = alu_y;
        carry = (alu_y < hi);
      end
      iter_hi = {carry, sum[XLEN-1:1]};
      iter_lo = {sum[0], lo[XLEN-1:1]};
    end
  end

  // Next-state and datapath update selection.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    op_next     = op_q;
    b_next      = b_q;
    hi_next     = hi;
    lo_next     = lo;
    result_next = resp_result;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_next = ST_RUN;
          op_next    = req_op;
          b_next     = req_b;
          hi_next    = '0;
          lo_next    = req_a;
          cnt_next   = '0;
        end
      end
      ST_RUN: begin
        hi_next  = iter_hi;
        lo_next  = iter_lo;
        cnt_next = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          state_next  = ST_DONE;
          result_next = sel_low(op_q) ? iter_lo : iter_hi;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      op_q        <= OP_MUL;
      b_q         <= '0;
      hi          <= '0;
      lo          <= '0;
      resp_result <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      op_q        <= op_next;
      b_q         <= b_next;
      hi          <= hi_next;
      lo          <= lo_next;
      resp_result <= result_next;
      req_ready   <= (state_next == ST_IDLE);
      resp_valid  <= (state_next == ST_DONE);
      busy        <= (state_next != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed vector bench for muldiv_seq: result values, latency, backpressure, mid-op reset.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  muldiv_op_e req_op;
  reg_t       req_a;
  reg_t       req_b;
  logic       resp_valid;
  logic       resp_ready;
  reg_t       resp_result;
  logic       busy;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    muldiv_op_e op;
    reg_t       a;
    reg_t       b;
    reg_t       exp;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];

  muldiv_seq dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op, scramble operands after accept, and measure edges until resp_valid.
  task automatic do_op(input muldiv_op_e op, input reg_t a, input reg_t b,
                       output reg_t res, output int lat);
    int wait_cnt;
    wait_cnt = 0;
    @(negedge clk);
    while (!req_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    req_op    = muldiv_op_e'(2'($urandom));
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = resp_result;
  endtask

  // Consume the pending response and confirm the return to IDLE.
  task automatic take_resp(input string name);
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check({name, "_valid_drop"}, 32'(resp_valid), 32'd0);
    check({name, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    reg_t res;
    int   lat;

    vecs[0]  = '{OP_MUL,   32'd7,          32'd6,          32'd42};
    vecs[1]  = '{OP_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
    vecs[2]  = '{OP_MUL,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
    vecs[3]  = '{OP_DIVU,  32'd100,        32'd7,          32'd14};
    vecs[4]  = '{OP_REMU,  32'd100,        32'd7,          32'd2};
    vecs[5]  = '{OP_DIVU,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    vecs[6]  = '{OP_DIVU,  32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[7]  = '{OP_REMU,  32'd5,          32'd0,          32'd5};
    vecs[8]  = '{OP_MULHU, 32'h8000_0000,  32'd4,          32'd2};
    vecs[9]  = '{OP_MUL,   32'h0001_0000,  32'h0001_0000,  32'd0};
    vecs[10] = '{OP_MULHU, 32'h0001_0000,  32'h0001_0000,  32'd1};
    vecs[11] = '{OP_DIVU,  32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
    vecs[12] = '{OP_REMU,  32'hFFFF_FFFF,  32'h10,         32'hF};
    vecs[13] = '{OP_DIVU,  32'd3,          32'd5,          32'd0};
    vecs[14] = '{OP_REMU,  32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE};
    vecs[15] = '{OP_DIVU,  32'hFFFF_FFFF,  32'h8000_0001,  32'd1};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = OP_MUL;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",   32'(req_ready),  32'd1);
    check("rst_resp_valid",  32'(resp_valid), 32'd0);
    check("rst_busy",        32'(busy),       32'd0);
    check("rst_resp_result", resp_result,     32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven result and latency checks.
    for (int i = 0; i < NVEC; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd32);
      take_resp($sformatf("vec%0d", i));
    end

    // Backpressure: hold DONE for 10 cycles with requests hammering the input.
    do_op(OP_DIVU, 32'd100, 32'd7, res, lat);
    check("bp_latency", 32'(lat), 32'd32);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OP_MUL;
      req_a     = (k % 2 == 0) ? 32'hDEAD_BEEF : 32'h1234_5678;
      req_b     = 32'd3;
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_valid", k),  32'(resp_valid), 32'd1);
      check($sformatf("bp%0d_result", k), resp_result,     32'd14);
      check($sformatf("bp%0d_ready", k),  32'(req_ready),  32'd0);
      check($sformatf("bp%0d_busy", k),   32'(busy),       32'd1);
    end
    @(negedge clk);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("bp_release_valid", 32'(resp_valid), 32'd0);
    check("bp_release_ready", 32'(req_ready),  32'd1);

    // Reset in the middle of a divide (cnt==15), then a fresh multiply.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_DIVU;
    req_a     = 32'd1000;
    req_b     = 32'd9;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_req_ready",   32'(req_ready),  32'd1);
    check("mrst_resp_valid",  32'(resp_valid), 32'd0);
    check("mrst_busy",        32'(busy),       32'd0);
    check("mrst_resp_result", resp_result,     32'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (resp_valid) seen++;
      end
      check("mrst_no_resp", 32'(seen), 32'd0);
    end
    do_op(OP_MUL, 32'd3, 32'd4, res, lat);
    check("post_rst_result",  res,      32'd12);
    check("post_rst_latency", 32'(lat), 32'd32);
    take_resp("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The module SHALL have port req_valid, input, 1 bit: requester presents an operation.
REQ-004 The module SHALL have port req_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-005 The module SHALL have port req_op, input, MulDivOp (2 bits): MUL=0, MULHU=1, DIVU=2, REMU=3.
REQ-006 The module SHALL have ports req_a and req_b, input, Reg (32 bits): unsigned operands.
REQ-007 The module SHALL have port resp_valid, output, 1 bit: result available.
REQ-008 The module SHALL have port resp_ready, input, 1 bit: consumer takes the result.
REQ-009 The module SHALL have port resp_result, output, Reg (32 bits): result, valid only while resp_valid is high.
REQ-010 The module SHALL have port busy, output, 1 bit: high when state is not IDLE.

Function
REQ-011 FSM states SHALL be IDLE, RUN and DONE.
REQ-012 req_ready SHALL be high exactly when state is IDLE; a request is accepted on an edge where req_valid and req_ready are both high.
REQ-013 On accept, the block SHALL latch op, a and b, clear iteration counter cnt (5 bits) and enter RUN.
REQ-014 RUN SHALL perform one iteration per cycle; after the iteration with cnt==31 it SHALL enter DONE, so resp_valid rises exactly 32 edges after the accept edge for every op and operand value.
REQ-015 DONE SHALL hold resp_valid high and resp_result stable until an edge where resp_ready is high, then return to IDLE; the next request can be accepted no earlier than the following edge.
REQ-016 All add and subtract arithmetic SHALL go through a single instance of the shared alu with operation ADD or SUB; there is no second adder.
REQ-017 MUL/MULHU iteration: {hi,lo} is 64 bits with hi=0 and lo=a at start.
- If lo[0], sum = alu ADD(hi, b) and carry = (sum < hi) via a local unsigned compare; otherwise sum = hi and carry = 0.
- Then {hi,lo} <= {carry,sum,lo} >> 1.
REQ-018 DIVU/REMU iteration (restoring): rem is 32 bits and quo is 32 bits, with rem=0 and quo=a at start.
- sh = {rem, quo[31]} (33 bits).
- If sh[32] or sh[31:0] >= b: rem <= alu SUB(sh[31:0], b) and the new quotient bit is 1; otherwise rem <= sh[31:0] and the new quotient bit is 0.
- quo <= {quo[30:0], new bit}.
REQ-019 The result SHALL be: MUL = lo, MULHU = hi, DIVU = quo, REMU = rem; all bits beyond 32 are discarded.
REQ-020 Divide by zero SHALL yield DIVU = 0xFFFFFFFF and REMU = a (the natural result of REQ-018, with no special path and the same 32-cycle latency).
REQ-021 req_* inputs SHALL be ignored outside IDLE; operand changes after accept SHALL NOT affect the result.

Reset
REQ-022 When reset is high at an edge, the state SHALL become IDLE, and req_ready=1, resp_valid=0, busy=0, resp_result=0, cnt=0 and all datapath registers 0; this overrides any concurrent accept or completion.
REQ-023 Reset during RUN or DONE SHALL abandon the operation, with no resp_valid pulse afterward.

Structure
REQ-024 MulDivOp, Reg and AluOp SHALL live in the shared types package; the iteration count (32) SHALL be a package constant.
REQ-025 muldiv_seq SHALL instantiate exactly one sub-module, alu, whose operation, a and b inputs are muxed by state and op.

Verification
REQ-026 The bench SHALL cover MUL 7 x 6: resp_result=42, and resp_valid rises 32 edges after accept.
REQ-027 The bench SHALL cover MULHU 0xFFFFFFFF x 0xFFFFFFFF: 0xFFFFFFFE; MUL with the same operands: 0x00000001 (carry path).
REQ-028 The bench SHALL cover DIVU 100/7: 14 and REMU 100/7: 2; DIVU 0x80000000/0xFFFFFFFF: 0 (sh[32] path unused, compare path).
REQ-029 The bench SHALL cover DIVU 5/0: 0xFFFFFFFF and REMU 5/0: 5, with the same latency.
REQ-030 The bench SHALL cover the following backpressure case.
- Stimulus: resp_ready held low 10 cycles in DONE, with req_valid high and req_a toggling throughout.
- Required response: resp_valid and the result remain stable, req_ready stays 0, and the result is unaffected.
REQ-031 The bench SHALL cover reset at cnt=15 of a DIVU.
- Required response: next cycle IDLE with all outputs at reset values, no resp_valid.
- A fresh MUL 3 x 4 then yields 12 at nominal latency.
